// File: rtl/core_fetch.sv
// Instruction prefetch: one bus read outstanding, results queued in a 2**PREFETCH_ORDER FIFO.
// Latency: accept -> insn two edges later. Backpressure: stall holds insn; fetch drops when FIFO + in-flight read would overflow.
module core_fetch #(
   parameter int          PREFETCH_ORDER = 2,
   parameter logic [29:0] RESET_PC       = 30'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        branch,
   input  logic [29:0] branch_target,
   output logic        fetch,
   output logic [29:0] fetch_addr,
   input  logic        fetch_ready,
   input  logic [31:0] fetch_data,
   output logic [31:0] insn,
   output logic [29:0] insn_pc,
   output logic        nop
);

   localparam int               DEPTH     = 1 << PREFETCH_ORDER;
   localparam int               PTR_W     = PREFETCH_ORDER + 1;
   localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);

   typedef struct packed {
      logic [31:0] word;
      logic [29:0] ptr;
   } entry_t;

   entry_t           mem [DEPTH];
   entry_t           head;
   logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, occ_n;
   logic [29:0]      next_pc, next_pc_n, fetch_addr_n, insn_pc_n;
   logic [31:0]      insn_n;
   logic             discard, discard_n, fetch_n, nop_n;
   logic             empty, accept, push, pop;

   assign empty  = (wr_ptr == rd_ptr);
   assign head   = mem[rd_ptr[PREFETCH_ORDER-1:0]];
   assign accept = fetch & fetch_ready;
   assign push   = accept & ~discard & ~branch;
   assign pop    = ~branch & ~stall & ~empty;

   always_comb begin
      wr_ptr_n     = wr_ptr;
      rd_ptr_n     = rd_ptr;
      next_pc_n    = next_pc;
      discard_n    = discard;
      fetch_n      = fetch;
      fetch_addr_n = fetch_addr;
      insn_n       = insn;
      insn_pc_n    = insn_pc;
      nop_n        = nop;

      if (branch) begin
         wr_ptr_n = '0;
         rd_ptr_n = '0;
      end else begin
         if (push) wr_ptr_n = wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr_n = rd_ptr + PTR_W'(1);
      end
      occ_n = wr_ptr_n - rd_ptr_n;

      if (branch)    next_pc_n = branch_target;
      else if (push) next_pc_n = fetch_addr + 30'd1;

      // A redirect while the bus still owes us a word must swallow that word later.
      if (accept)                discard_n = 1'b0;
      else if (fetch && branch)  discard_n = 1'b1;

      if (!(fetch && !fetch_ready)) begin
         fetch_n      = (occ_n < DEPTH_CNT);
         fetch_addr_n = next_pc_n;
      end

      if (branch) begin
         nop_n = 1'b1;
      end else if (!stall) begin
         if (!empty) begin
            insn_n    = head.word;
            insn_pc_n = head.ptr;
            nop_n     = 1'b0;
         end else begin
            nop_n = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PREFETCH_ORDER-1:0]] <= '{word: fetch_data, ptr: fetch_addr};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         next_pc    <= RESET_PC;
         discard    <= 1'b0;
         fetch      <= 1'b0;
         fetch_addr <= RESET_PC;
         insn       <= 32'h0;
         insn_pc    <= RESET_PC;
         nop        <= 1'b1;
      end else begin
         wr_ptr     <= wr_ptr_n;
         rd_ptr     <= rd_ptr_n;
         next_pc    <= next_pc_n;
         discard    <= discard_n;
         fetch      <= fetch_n;
         fetch_addr <= fetch_addr_n;
         insn       <= insn_n;
         insn_pc    <= insn_pc_n;
         nop        <= nop_n;
      end
   end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: directed table, hand-written corner sequences, then random traffic vs a queue-based model.
module tb_core_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic [29:0] branch_target = '0;
   logic        fetch;
   logic [29:0] fetch_addr;
   logic        fetch_ready = 1'b0;
   logic [31:0] fetch_data;
   logic [31:0] insn;
   logic [29:0] insn_pc;
   logic        nop;

   int checks = 0;
   int failures = 0;

   core_fetch dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch),
      .branch_target(branch_target), .fetch(fetch), .fetch_addr(fetch_addr),
      .fetch_ready(fetch_ready), .fetch_data(fetch_data), .insn(insn),
      .insn_pc(insn_pc), .nop(nop)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bus_word(input logic [29:0] a);
      return {a, 2'b01} ^ 32'hA5C3_0F1E;
   endfunction

   assign fetch_data = bus_word(fetch_addr);

   // Reference model: FIFO contents as a queue of word addresses.
   logic [29:0] q[$];
   logic        m_fetch, m_disc, m_nop;
   logic [29:0] m_addr, m_next, m_pc;
   logic [31:0] m_insn;

   task automatic model_reset();
      q.delete();
      m_fetch = 1'b0; m_disc = 1'b0; m_nop = 1'b1;
      m_addr = '0; m_next = '0; m_pc = '0; m_insn = '0;
   endtask

   task automatic model_edge(input logic s, input logic b, input logic [29:0] t, input logic r);
      logic        acc;
      logic [29:0] nxt;
      acc = m_fetch && r;
      nxt = m_next;
      if (b) begin
         q.delete();
         m_nop = 1'b1;
      end else if (!s) begin
         if (q.size() > 0) begin
            m_pc = q.pop_front();
            m_insn = bus_word(m_pc);
            m_nop = 1'b0;
         end else begin
            m_nop = 1'b1;
         end
      end
      if (acc && !m_disc && !b) begin
         q.push_back(m_addr);
         nxt = m_addr + 30'd1;
      end
      if (b) nxt = t;
      m_next = nxt;
      if (acc) m_disc = 1'b0;
      else if (m_fetch && b) m_disc = 1'b1;
      if (!(m_fetch && !r)) begin
         m_fetch = (q.size() < DEPTH);
         m_addr = nxt;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_fetch"}, fetch, 0);
      chk({tag, "_addr"}, fetch_addr, 0);
      chk({tag, "_nop"}, nop, 1);
      chk({tag, "_insn"}, insn, 0);
      chk({tag, "_pc"}, insn_pc, 0);
   endtask

   // Called just after a rising edge; the whole pulse stays clear of the next edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk_reset("rst");
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic tick(input logic s, input logic b, input logic [29:0] t, input logic r);
      stall = s; branch = b; branch_target = t; fetch_ready = r;
      @(posedge clk);
      model_edge(s, b, t, r);
      #1;
   endtask

   typedef struct packed {
      logic        rst, s, b, r, ef;
      logic [29:0] ea;
      logic        en;
      logic [29:0] ep;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic rst, input logic s, input logic b, input logic r,
                      input logic ef, input logic [29:0] ea, input logic en, input logic [29:0] ep);
      tbl.push_back('{rst: rst, s: s, b: b, r: r, ef: ef, ea: ea, en: en, ep: ep});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      logic ok, bad, seen;
      logic s, b, r;
      logic [29:0] t;

      // rst, stall, branch, ready | exp fetch, fetch_addr, nop, insn_pc
      add(1,0,0,1, 1,0,1,0);
      add(0,0,0,1, 1,1,1,0);
      add(0,0,0,1, 1,2,0,0);
      add(0,0,0,1, 1,3,0,1);
      add(0,0,0,1, 1,4,0,2);
      add(1,1,0,1, 1,0,1,0);
      add(0,1,0,1, 1,1,1,0);
      add(0,1,0,1, 1,2,1,0);
      add(0,1,0,1, 1,3,1,0);
      for (int i = 0; i < 6; i++) add(0,1,0,1, 0,0,1,0);
      add(0,0,0,1, 1,4,0,0);
      add(0,0,0,1, 1,5,0,1);
      add(0,0,0,1, 1,6,0,2);
      add(0,0,0,1, 1,7,0,3);
      add(0,0,0,1, 1,8,0,4);

      model_reset();
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         tick(tbl[i].s, tbl[i].b, '0, tbl[i].r);
         chk($sformatf("tbl%0d_fetch", i), fetch, tbl[i].ef);
         if (tbl[i].ef) chk($sformatf("tbl%0d_addr", i), fetch_addr, tbl[i].ea);
         chk($sformatf("tbl%0d_nop", i), nop, tbl[i].en);
         if (!tbl[i].en) begin
            chk($sformatf("tbl%0d_pc", i), insn_pc, tbl[i].ep);
            chk($sformatf("tbl%0d_insn", i), insn, bus_word(tbl[i].ep));
         end
      end

      // Branch while a read is in flight: the stale word is dropped.
      do_reset();
      ok = 1'b0;
      for (int i = 0; i < 60 && !ok; i++) begin
         tick(0, 0, '0, 1);
         if (fetch && fetch_addr == 30'h10) ok = 1'b1;
      end
      chk("disc_reach", ok, 1);
      tick(0, 0, '0, 0);
      chk("disc_hold0", fetch_addr, 30'h10);
      tick(0, 1, 30'h200, 0);
      chk("disc_br_fetch", fetch, 1);
      chk("disc_br_addr", fetch_addr, 30'h10);
      chk("disc_br_nop", nop, 1);
      tick(0, 0, '0, 0);
      chk("disc_hold1", fetch_addr, 30'h10);
      tick(0, 0, '0, 1);
      chk("disc_new_fetch", fetch, 1);
      chk("disc_new_addr", fetch_addr, 30'h200);
      bad = 1'b0; seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick(0, 0, '0, 1);
         if (!nop && insn_pc == 30'h10) bad = 1'b1;
         if (!nop) begin
            seen = 1'b1;
            chk("disc_first_pc", insn_pc, 30'h200);
            chk("disc_first_insn", insn, bus_word(30'h200));
         end
      end
      chk("disc_delivered", seen, 1);
      chk("disc_no_stale", bad, 0);

      // Branch with stall on a full FIFO.
      do_reset();
      for (int i = 0; i < 8; i++) tick(1, 0, '0, 1);
      chk("full_fetch_low", fetch, 0);
      tick(1, 1, 30'h1234, 1);
      chk("bfull_nop", nop, 1);
      chk("bfull_fetch", fetch, 1);
      chk("bfull_addr", fetch_addr, 30'h1234);
      tick(0, 0, '0, 1);
      chk("bfull_empty", nop, 1);
      chk("bfull_next", fetch_addr, 30'h1235);
      tick(0, 0, '0, 1);
      chk("bfull_pc_nop", nop, 0);
      chk("bfull_pc", insn_pc, 30'h1234);
      chk("bfull_insn", insn, bus_word(30'h1234));

      // Address wrap at the top of the word space.
      do_reset();
      tick(0, 0, '0, 1);
      tick(0, 1, 30'h3FFF_FFFF, 1);
      chk("wrap_addr_top", fetch_addr, 30'h3FFF_FFFF);
      tick(0, 0, '0, 1);
      chk("wrap_addr_zero", fetch_addr, 30'h0);
      tick(0, 0, '0, 1);
      chk("wrap_pc_top", insn_pc, 30'h3FFF_FFFF);
      chk("wrap_nop_top", nop, 0);
      tick(0, 0, '0, 1);
      chk("wrap_pc_zero", insn_pc, 30'h0);

      // Reset mid-transaction, with a branch presented during reset.
      do_reset();
      for (int i = 0; i < 3; i++) tick(0, 0, '0, 1);
      tick(0, 0, '0, 0);
      chk("mid_pending", fetch, 1);
      rst_n = 1'b0;
      #1;
      chk_reset("mid_async");
      branch = 1'b1; branch_target = 30'h777; fetch_ready = 1'b1;
      @(posedge clk);
      #1;
      chk_reset("mid_held");
      rst_n = 1'b1;
      branch = 1'b0;
      model_reset();
      tick(0, 0, '0, 1);
      chk("mid_first_fetch", fetch, 1);
      chk("mid_first_addr", fetch_addr, 30'h0);
      seen = 1'b0;
      for (int i = 0; i < 6 && !seen; i++) begin
         tick(0, 0, '0, 1);
         if (!nop) begin
            seen = 1'b1;
            chk("mid_first_pc", insn_pc, 30'h0);
         end
      end
      chk("mid_delivered", seen, 1);

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         s = ($urandom_range(0, 99) < 30);
         b = ($urandom_range(0, 99) < 5);
         r = ($urandom_range(0, 99) < 65);
         if ($urandom_range(0, 3) == 0) t = 30'h3FFF_FFFF - 30'($urandom_range(0, 3));
         else t = 30'($urandom);
         if ($urandom_range(0, 499) == 0) do_reset();
         tick(s, b, t, r);
         chk("r_fetch", fetch, m_fetch);
         if (m_fetch) chk("r_addr", fetch_addr, m_addr);
         chk("r_nop", nop, m_nop);
         if (!m_nop) begin
            chk("r_pc", insn_pc, m_pc);
            chk("r_insn", insn, m_insn);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
